pingpong_sram_writer: RTL and testbench

PINGPONG_SRAM_WRITER -- requirements
Module: pingpong_sram_writer

---
 rtl/pingpong_sram_writer.sv | 137 +++++++++++++
 tb/tb_pingpong_sram_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_sram_writer.sv
// Ping-pong SRAM writer: streams producer words into the bank not being read,
// one stage at a time, and holds off the producer until the reader swaps banks.
module pingpong_sram_writer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W:0]   stage_len,
    input  logic              new_stage_trigger,
    input  logic              select_sram,
    output logic              status,
    output logic              sram_a_we,
    output logic [ADDR_W-1:0] sram_a_addr,
    output logic [DATA_W-1:0] sram_a_wdata,
    output logic              sram_b_we,
    output logic [ADDR_W-1:0] sram_b_addr,
    output logic [DATA_W-1:0] sram_b_wdata,
    output logic [ADDR_W:0]   words_written,
    output logic              err_swap
);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_e;

    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              status_q, status_d;
    logic              a_we_q, a_we_d;
    logic              b_we_q, b_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   stage_len_q, stage_len_d;
    logic              sel_prev_q, sel_prev_d;
    logic              err_q, err_d;

    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   wr_next;

    // Zero or oversized lengths mean a full bank, so the address never wraps.
    assign len_eff = ((stage_len == '0) || (stage_len > DEPTH_W)) ? DEPTH_W : stage_len;
    assign wr_next = wr_addr_q + 1'b1;

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        status_d    = status_q;
        a_we_d      = 1'b0;
        b_we_d      = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_addr_d   = wr_addr_q;
        stage_len_d = stage_len_q;
        sel_prev_d  = select_sram;
        // in_ready_q is high exactly while an active FILL is accepting words.
        err_d       = err_q | (in_ready_q && (select_sram != sel_prev_q));

        unique case (state_q)
            FILL: begin
                if (!in_ready_q) begin
                    // First clock after reset release: open the stage.
                    in_ready_d  = 1'b1;
                    stage_len_d = len_eff;
                end else if (in_valid) begin
                    a_we_d    = select_sram;
                    b_we_d    = ~select_sram;
                    addr_d    = wr_addr_q[ADDR_W-1:0];
                    wdata_d   = in_data;
                    wr_addr_d = wr_next;
                    if (wr_next == stage_len_q) begin
                        state_d    = FULL;
                        status_d   = 1'b1;
                        in_ready_d = 1'b0;
                    end
                end
            end
            FULL: begin
                if (new_stage_trigger) begin
                    state_d     = FILL;
                    status_d    = 1'b0;
                    in_ready_d  = 1'b1;
                    wr_addr_d   = '0;
                    stage_len_d = len_eff;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b0;
            status_q    <= 1'b0;
            a_we_q      <= 1'b0;
            b_we_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_addr_q   <= '0;
            stage_len_q <= DEPTH_W;
            sel_prev_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            status_q    <= status_d;
            a_we_q      <= a_we_d;
            b_we_q      <= b_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_addr_q   <= wr_addr_d;
            stage_len_q <= stage_len_d;
            sel_prev_q  <= sel_prev_d;
            err_q       <= err_d;
        end
    end

    // Both banks see the same registered address/data; only the strobes differ.
    assign in_ready      = in_ready_q;
    assign status        = status_q;
    assign sram_a_we     = a_we_q;
    assign sram_a_addr   = addr_q;
    assign sram_a_wdata  = wdata_q;
    assign sram_b_we     = b_we_q;
    assign sram_b_addr   = addr_q;
    assign sram_b_wdata  = wdata_q;
    assign words_written = wr_addr_q;
    assign err_swap      = err_q;

endmodule

// File: tb/tb_pingpong_sram_writer.sv
// Directed bench for pingpong_sram_writer: a per-cycle vector table for the
// basic fill/swap flow plus hand sequences for reset, error and full-depth cases.
module tb_pingpong_sram_writer;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W:0]   stage_len;
    logic              new_stage_trigger;
    logic              select_sram;
    logic              status;
    logic              sram_a_we;
    logic [ADDR_W-1:0] sram_a_addr;
    logic [DATA_W-1:0] sram_a_wdata;
    logic              sram_b_we;
    logic [ADDR_W-1:0] sram_b_addr;
    logic [DATA_W-1:0] sram_b_wdata;
    logic [ADDR_W:0]   words_written;
    logic              err_swap;

    int checks   = 0;
    int failures = 0;

    pingpong_sram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_ready          (in_ready),
        .stage_len         (stage_len),
        .new_stage_trigger (new_stage_trigger),
        .select_sram       (select_sram),
        .status            (status),
        .sram_a_we         (sram_a_we),
        .sram_a_addr       (sram_a_addr),
        .sram_a_wdata      (sram_a_wdata),
        .sram_b_we         (sram_b_we),
        .sram_b_addr       (sram_b_addr),
        .sram_b_wdata      (sram_b_wdata),
        .words_written     (words_written),
        .err_swap          (err_swap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        sel;
        logic        trig;
        logic [8:0]  len;
        logic        a_we;
        logic        b_we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        stat;
        logic        rdy;
        logic [8:0]  words;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic sel, input logic trig);
        in_valid          = v;
        in_data           = d;
        select_sram       = sel;
        new_stage_trigger = trig;
    endtask

    task automatic check_write(input string tag, input logic a_we, input logic b_we,
                               input logic [7:0] addr, input logic [31:0] wdata);
        check({tag, ".a_we"}, 64'(sram_a_we), 64'(a_we));
        check({tag, ".b_we"}, 64'(sram_b_we), 64'(b_we));
        if (a_we) begin
            check({tag, ".a_addr"},  64'(sram_a_addr),  64'(addr));
            check({tag, ".a_wdata"}, 64'(sram_a_wdata), 64'(wdata));
        end
        if (b_we) begin
            check({tag, ".b_addr"},  64'(sram_b_addr),  64'(addr));
            check({tag, ".b_wdata"}, 64'(sram_b_wdata), 64'(wdata));
        end
    endtask

    // Reset with the given stage length, release, and run the first clock that opens the stage.
    task automatic do_reset(input logic [8:0] len, input logic sel);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, sel, 1'b0);
        stage_len = len;
        step();
        rst_n = 1'b1;
        check("post_rel.rdy", 64'(in_ready), 64'd0);
        step();
        check("first_clk.rdy",   64'(in_ready),      64'd1);
        check("first_clk.words", 64'(words_written), 64'd0);
        check("first_clk.err",   64'(err_swap),      64'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        stage_len = 9'd4;

        //       v   data    sel  trg len   a_we b_we addr  wdata   stat rdy words
        vecs[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 9'd4, 1'b0, 1'b1, 8'd0, 32'h11, 1'b0, 1'b1, 9'd1};
        vecs[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 9'd4, 1'b0, 1'b1, 8'd1, 32'h22, 1'b0, 1'b1, 9'd2};
        vecs[2] = '{1'b0, 32'h00, 1'b0, 1'b1, 9'd4, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 9'd2};
        vecs[3] = '{1'b1, 32'h33, 1'b0, 1'b0, 9'd4, 1'b0, 1'b1, 8'd2, 32'h33, 1'b0, 1'b1, 9'd3};
        vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b0, 9'd4, 1'b0, 1'b1, 8'd3, 32'h44, 1'b1, 1'b0, 9'd4};
        vecs[5] = '{1'b1, 32'h55, 1'b0, 1'b0, 9'd4, 1'b0, 1'b0, 8'd0, 32'h00, 1'b1, 1'b0, 9'd4};
        vecs[6] = '{1'b1, 32'h55, 1'b1, 1'b1, 9'd4, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 9'd0};
        vecs[7] = '{1'b1, 32'h55, 1'b1, 1'b0, 9'd4, 1'b1, 1'b0, 8'd0, 32'h55, 1'b0, 1'b1, 9'd1};
        vecs[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 9'd2, 1'b0, 1'b0, 8'd0, 32'h00, 1'b0, 1'b1, 9'd1};
        vecs[9] = '{1'b1, 32'h66, 1'b1, 1'b0, 9'd2, 1'b1, 1'b0, 8'd1, 32'h66, 1'b0, 1'b1, 9'd2};

        // Asynchronous reset state, checked between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst.rdy",    64'(in_ready),      64'd0);
        check("rst.status", 64'(status),        64'd0);
        check("rst.a_we",   64'(sram_a_we),     64'd0);
        check("rst.b_we",   64'(sram_b_we),     64'd0);
        check("rst.addr",   64'(sram_a_addr),   64'd0);
        check("rst.wdata",  64'(sram_b_wdata),  64'd0);
        check("rst.words",  64'(words_written), 64'd0);
        check("rst.err",    64'(err_swap),      64'd0);

        // Fill into B, ignored mid-fill trigger, backpressure, swap, fill into A.
        do_reset(9'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].sel, vecs[i].trig);
            stage_len = vecs[i].len;
            step();
            check_write($sformatf("vec%0d", i), vecs[i].a_we, vecs[i].b_we, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d.status", i), 64'(status),        64'(vecs[i].stat));
            check($sformatf("vec%0d.rdy", i),    64'(in_ready),      64'(vecs[i].rdy));
            check($sformatf("vec%0d.words", i),  64'(words_written), 64'(vecs[i].words));
            check($sformatf("vec%0d.err", i),    64'(err_swap),      64'd0);
        end

        // Read bank flips back to A mid-fill: sticky error, writes follow ~select_sram.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        check("swap.err_set", 64'(err_swap), 64'd1);
        drive(1'b1, 32'h77, 1'b0, 1'b0);
        step();
        check_write("swap.wr", 1'b0, 1'b1, 8'd2, 32'h77);
        check("swap.err_hold1", 64'(err_swap), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        check("swap.err_hold2", 64'(err_swap), 64'd1);
        rst_n = 1'b0;
        #1;
        check("swap.err_clr", 64'(err_swap), 64'd0);

        // Reset after 3 of 8 writes abandons the stage; writes restart at 0.
        do_reset(9'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
            step();
            check_write($sformatf("mid.wr%0d", i), 1'b0, 1'b1, 8'(i), 32'hA0 + 32'(i));
        end
        #2 rst_n = 1'b0;
        #1;
        check("mid.b_we",   64'(sram_b_we),     64'd0);
        check("mid.a_we",   64'(sram_a_we),     64'd0);
        check("mid.status", 64'(status),        64'd0);
        check("mid.words",  64'(words_written), 64'd0);
        do_reset(9'd8, 1'b0);
        drive(1'b1, 32'hAA, 1'b0, 1'b0);
        step();
        check_write("mid.restart", 1'b0, 1'b1, 8'd0, 32'hAA);
        check("mid.restart_words", 64'(words_written), 64'd1);

        // stage_len = 0 means 256 words: addresses 0..255, no wrap, then FULL.
        do_reset(9'd0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
            step();
            check_write($sformatf("full.wr%0d", i), 1'b0, 1'b1, 8'(i), 32'h1000 + 32'(i));
            check($sformatf("full.status%0d", i), 64'(status), 64'(i == 255));
        end
        check("full.rdy",   64'(in_ready),      64'd0);
        check("full.words", 64'(words_written), 64'd256);
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
        step();
        check_write("full.held", 1'b0, 1'b0, 8'd0, 32'h0);
        check("full.held_words", 64'(words_written), 64'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
